// File: rtl/stream_arb_mux_pkg.sv
// Shared constants, FSM encoding and sizing helper for the arbitrated stream multiplexer.
package stream_arb_mux_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Ceiling log2, used for channel-index widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational channel arbiter: fixed-priority or round-robin search, with an optional lock override.
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned ARB_MODE   = ARB_RR,
  localparam int unsigned SEL_WIDTH = clog2(N_CHANNELS)
) (
  input  logic [N_CHANNELS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  ptr,
  input  logic                  lock_en,
  input  logic [SEL_WIDTH-1:0]  lock_idx,
  output logic [N_CHANNELS-1:0] grant_onehot,
  output logic [SEL_WIDTH-1:0]  grant_idx,
  output logic                  any_grant
);

  localparam logic [SEL_WIDTH:0] N_W = (SEL_WIDTH + 1)'(N_CHANNELS);

  logic [SEL_WIDTH:0] cand;

  // While locked only the held channel may win; otherwise search from 0 or from ptr with wrap.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    cand         = '0;
    if (lock_en) begin
      if (req[lock_idx]) begin
        any_grant = 1'b1;
        grant_idx = lock_idx;
      end
    end else begin
      for (int unsigned k = 0; k < N_CHANNELS; k++) begin
        if (ARB_MODE == ARB_FIXED) begin
          cand = (SEL_WIDTH + 1)'(k);
        end else begin
          cand = {1'b0, ptr} + (SEL_WIDTH + 1)'(k);
          if (cand >= N_W) cand = cand - N_W;
        end
        if (!any_grant && req[cand[SEL_WIDTH-1:0]]) begin
          any_grant = 1'b1;
          grant_idx = cand[SEL_WIDTH-1:0];
        end
      end
    end
    if (any_grant) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel registered stream multiplexer with internal arbitration and optional packet lock.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned ARB_MODE    = ARB_RR,
  parameter int unsigned PACKET_LOCK = 1,
  localparam int unsigned SEL_WIDTH  = clog2(N_CHANNELS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CHANNELS*BUS_WIDTH-1:0] in_data,
  input  logic [N_CHANNELS-1:0]           in_valid,
  input  logic [N_CHANNELS-1:0]           in_last,
  output logic [N_CHANNELS-1:0]           in_ready,
  output logic [BUS_WIDTH-1:0]            out,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [SEL_WIDTH-1:0]            out_sel,
  input  logic                            out_ready
);

  lock_state_e           state;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  lock_idx;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [SEL_WIDTH-1:0]  ptr_next;
  logic [N_CHANNELS-1:0] grant_onehot;
  logic                  any_grant;
  logic                  lock_en;
  logic                  can_load;
  logic                  xfer_in;
  logic                  ends_arb;
  logic                  sel_last;
  logic [BUS_WIDTH-1:0]  sel_data;

  assign lock_en = (PACKET_LOCK != 0) && (state == LOCKED);

  rr_arbiter #(
    .N_CHANNELS(N_CHANNELS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .lock_en     (lock_en),
    .lock_idx    (lock_idx),
    .grant_onehot(grant_onehot),
    .grant_idx   (grant_idx),
    .any_grant   (any_grant)
  );

  // Ready is held low during reset so no beat is accepted into a register being cleared.
  assign can_load = ~out_valid | out_ready;
  assign in_ready = (can_load && !reset) ? grant_onehot : '0;
  assign xfer_in  = can_load & ~reset & any_grant;
  assign ends_arb = (PACKET_LOCK == 0) || sel_last;
  assign ptr_next = (grant_idx == SEL_WIDTH'(N_CHANNELS - 1)) ? '0 : grant_idx + SEL_WIDTH'(1);

  // AND-OR data/last select over the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      sel_data = sel_data | (in_data[i*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{grant_onehot[i]}});
      sel_last = sel_last | (in_last[i] & grant_onehot[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
      lock_idx  <= '0;
      state     <= IDLE;
    end else begin
      if (xfer_in) begin
        out       <= sel_data;
        out_last  <= sel_last;
        out_sel   <= grant_idx;
        out_valid <= 1'b1;
        if (ends_arb) ptr <= ptr_next;
        if (PACKET_LOCK != 0) begin
          state    <= sel_last ? IDLE : LOCKED;
          lock_idx <= grant_idx;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed, table-driven bench for stream_arb_mux (round-robin/locked instance plus a fixed-priority instance).
module tb_stream_arb_mux;
  import stream_arb_mux_pkg::*;

  localparam int unsigned BW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned NV = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*BW-1:0] in_data;
  logic [N-1:0]  in_valid, in_last, in_ready, in_ready_fp;
  logic          out_ready;
  logic [BW-1:0] out, out_fp;
  logic          out_valid, out_valid_fp, out_last, out_last_fp;
  logic [SW-1:0] out_sel, out_sel_fp;

  always #5 clk = ~clk;

  stream_arb_mux #(.BUS_WIDTH(BW), .N_CHANNELS(N), .ARB_MODE(1), .PACKET_LOCK(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  stream_arb_mux #(.BUS_WIDTH(BW), .N_CHANNELS(N), .ARB_MODE(0), .PACKET_LOCK(0)) dut_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_fp), .out(out_fp), .out_valid(out_valid_fp), .out_last(out_last_fp),
    .out_sel(out_sel_fp), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [7:0] seed;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_out;
    logic [1:0] exp_sel;
    logic       exp_last;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;
  int   proto_bad = 0;
  logic proto_en = 1'b0;
  logic [N-1:0] pend;

  // A valid that was not accepted must stay up on the main instance's inputs.
  always @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (proto_en) begin
        assert ((pend & ~in_valid) == '0)
        else begin
          proto_bad++;
          $display("FAIL protocol: valid dropped before transfer pend=%b valid=%b", pend, in_valid);
        end
      end
      pend <= in_valid & ~in_ready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r, input logic [7:0] seed);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    for (int i = 0; i < int'(N); i++) in_data[i*BW +: BW] = seed + 8'(i);
  endtask

  initial begin
    // valid, last, ordy, seed | exp_rdy, exp_ov, exp_out, exp_sel, exp_last
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 8'hA0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 8'hA0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 8'hA0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 8'hA0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 8'hA0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[5]  = '{4'b1111, 4'b1111, 1'b0, 8'hA0, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[6]  = '{4'b1111, 4'b1111, 1'b0, 8'hA0, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[7]  = '{4'b1111, 4'b1111, 1'b0, 8'hA0, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 8'hA0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
    vecs[9]  = '{4'b1101, 4'b1111, 1'b1, 8'hA0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1};
    vecs[10] = '{4'b1001, 4'b1111, 1'b1, 8'hA0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1};
    vecs[11] = '{4'b0001, 4'b1111, 1'b0, 8'hA0, 4'b0000, 1'b1, 8'hA3, 2'd3, 1'b1};
    vecs[12] = '{4'b0001, 4'b1111, 1'b1, 8'hA0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[13] = '{4'b0000, 4'b1111, 1'b1, 8'hA0, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b1};
    vecs[14] = '{4'b0000, 4'b1111, 1'b0, 8'hA0, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b1};
    vecs[15] = '{4'b0101, 4'b0001, 1'b1, 8'h10, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b0};
    vecs[16] = '{4'b0101, 4'b0001, 1'b1, 8'h20, 4'b0100, 1'b1, 8'h22, 2'd2, 1'b0};
    vecs[17] = '{4'b0001, 4'b0001, 1'b1, 8'h30, 4'b0000, 1'b0, 8'h22, 2'd2, 1'b0};
    vecs[18] = '{4'b0101, 4'b0101, 1'b1, 8'h40, 4'b0100, 1'b1, 8'h42, 2'd2, 1'b1};
    vecs[19] = '{4'b1001, 4'b1001, 1'b1, 8'h50, 4'b1000, 1'b1, 8'h53, 2'd3, 1'b1};
    vecs[20] = '{4'b0001, 4'b0001, 1'b1, 8'h60, 4'b0001, 1'b1, 8'h60, 2'd0, 1'b1};
    vecs[21] = '{4'b0000, 4'b0001, 1'b1, 8'h60, 4'b0000, 1'b0, 8'h60, 2'd0, 1'b1};

    // Reset held two cycles with every channel requesting.
    reset = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 8'hA0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset in_ready", 32'(in_ready), 32'h0);
      chk("reset out_valid", 32'(out_valid), 32'h0);
    end
    @(negedge clk);
    reset    = 1'b0;
    proto_en = 1'b1;

    for (int k = 0; k < int'(NV); k++) begin
      drive(vecs[k].valid, vecs[k].last, vecs[k].ordy, vecs[k].seed);
      #1;
      chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
      chk($sformatf("v%0d out", k), 32'(out), 32'(vecs[k].exp_out));
      chk($sformatf("v%0d out_sel", k), 32'(out_sel), 32'(vecs[k].exp_sel));
      chk($sformatf("v%0d out_last", k), 32'(out_last), 32'(vecs[k].exp_last));
      @(negedge clk);
    end
    proto_en = 1'b0;

    // Reset while LOCKED(2): packet dropped, FSM idle, pointer back to 0.
    drive(4'b0101, 4'b0000, 1'b1, 8'h70);
    #1 chk("midpkt first in_ready", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    chk("midpkt first out", 32'(out), 32'h72);
    chk("midpkt locked state", 32'(dut.state), 32'(LOCKED));
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midpkt reset in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("midpkt out_valid", 32'(out_valid), 32'h0);
    chk("midpkt state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0101, 4'b0101, 1'b1, 8'h80);
    #1 chk("post reset grant", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post reset out", 32'(out), 32'h80);
    chk("post reset out_sel", 32'(out_sel), 32'h0);
    @(negedge clk);

    // Fixed priority: ch1 always beats ch3.
    for (int c = 0; c < 6; c++) begin
      drive(4'b1010, 4'b1010, 1'b1, 8'hB0);
      #1 chk($sformatf("fp%0d in_ready", c), 32'(in_ready_fp), 32'b0010);
      @(posedge clk); #1;
      chk($sformatf("fp%0d out", c), 32'(out_fp), 32'hB1);
      chk($sformatf("fp%0d out_sel", c), 32'(out_sel_fp), 32'h1);
      chk($sformatf("fp%0d out_valid", c), 32'(out_valid_fp), 32'h1);
      @(negedge clk);
    end
    drive(4'b1000, 4'b1000, 1'b1, 8'hB0);
    #1 chk("fp top channel in_ready", 32'(in_ready_fp), 32'b1000);
    @(posedge clk); #1;
    chk("fp top channel out", 32'(out_fp), 32'hB3);
    chk("fp top channel out_sel", 32'(out_sel_fp), 32'h3);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b1, 8'h00);

    chk("protocol violations", 32'(proto_bad), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
